// File: rtl/id_operand_fetch.sv
// ID-stage operand fetch: 32-entry register file with WB bypass
// and the ID/EX operand latch with stall/flush control.
module id_operand_fetch #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic              valid_id,
  input  logic [4:0]        rd_wb,
  input  logic              we_wb,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] busA_ex,
  output logic [DATA_W-1:0] busB_ex,
  output logic [4:0]        rs1_ex,
  output logic [4:0]        rs2_ex,
  output logic              valid_ex,
  output logic              byp1_ex,
  output logic              byp2_ex
);

  logic [DATA_W-1:0] rf_q [32];

  logic              hit1, hit2;
  logic [DATA_W-1:0] op_a, op_b;

  logic [DATA_W-1:0] busa_q, busa_d;
  logic [DATA_W-1:0] busb_q, busb_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic              vld_q, vld_d;
  logic              byp1_q, byp1_d;
  logic              byp2_q, byp2_d;

  // Register file write; r0 is never written so it stays 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_q <= '{default: '0};
    end else if (we_wb && (rd_wb != 5'd0)) begin
      rf_q[rd_wb] <= wb_data;
    end
  end

  // Array read with same-cycle WB bypass; r0 excluded.
  always_comb begin
    hit1 = we_wb && (rd_wb == rs1_id) && (rs1_id != 5'd0);
    hit2 = we_wb && (rd_wb == rs2_id) && (rs2_id != 5'd0);
    op_a = '0;
    op_b = '0;
    unique case (1'b1)
      hit1:              op_a = wb_data;
      (rs1_id == 5'd0):  op_a = '0;
      default:           op_a = rf_q[rs1_id];
    endcase
    unique case (1'b1)
      hit2:              op_b = wb_data;
      (rs2_id == 5'd0):  op_b = '0;
      default:           op_b = rf_q[rs2_id];
    endcase
  end

  // ID/EX next state: flush beats stall.
  always_comb begin
    busa_d = busa_q;
    busb_d = busb_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    vld_d  = vld_q;
    byp1_d = byp1_q;
    byp2_d = byp2_q;
    if (flush) begin
      busa_d = '0;
      busb_d = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      vld_d  = 1'b0;
      byp1_d = 1'b0;
      byp2_d = 1'b0;
    end else if (!stall) begin
      busa_d = op_a;
      busb_d = op_b;
      rs1_d  = rs1_id;
      rs2_d  = rs2_id;
      vld_d  = valid_id;
      byp1_d = hit1;
      byp2_d = hit2;
    end
  end

  // ID/EX latch register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busa_q <= '0;
      busb_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      vld_q  <= 1'b0;
      byp1_q <= 1'b0;
      byp2_q <= 1'b0;
    end else begin
      busa_q <= busa_d;
      busb_q <= busb_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      vld_q  <= vld_d;
      byp1_q <= byp1_d;
      byp2_q <= byp2_d;
    end
  end

  assign busA_ex  = busa_q;
  assign busB_ex  = busb_q;
  assign rs1_ex   = rs1_q;
  assign rs2_ex   = rs2_q;
  assign valid_ex = vld_q;
  assign byp1_ex  = byp1_q;
  assign byp2_ex  = byp2_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: directed steps plus random
// traffic checked against a behavioural register-file model.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rs1_id, rs2_id, rd_wb;
  logic        valid_id, we_wb, stall, flush;
  logic [31:0] wb_data;
  logic [31:0] busA_ex, busB_ex;
  logic [4:0]  rs1_ex, rs2_ex;
  logic        valid_ex, byp1_ex, byp2_ex;

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] m_rf [32];
  logic [31:0] e_a, e_b;
  logic [4:0]  e_r1, e_r2;
  logic        e_v, e_h1, e_h2;

  id_operand_fetch #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .valid_id(valid_id), .rd_wb(rd_wb),
    .we_wb(we_wb), .wb_data(wb_data),
    .stall(stall), .flush(flush),
    .busA_ex(busA_ex), .busB_ex(busB_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .valid_ex(valid_ex),
    .byp1_ex(byp1_ex), .byp2_ex(byp2_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".busA"}, busA_ex, e_a);
    chk({tag, ".busB"}, busB_ex, e_b);
    chk({tag, ".rs1"}, 32'(rs1_ex), 32'(e_r1));
    chk({tag, ".rs2"}, 32'(rs2_ex), 32'(e_r2));
    chk({tag, ".vld"}, 32'(valid_ex), 32'(e_v));
    chk({tag, ".byp1"}, 32'(byp1_ex), 32'(e_h1));
    chk({tag, ".byp2"}, 32'(byp2_ex), 32'(e_h2));
  endtask

  function automatic logic [31:0] rd_op(input logic [4:0] ix,
                                        output logic hit);
    hit = we_wb && (rd_wb == ix) && (ix != 0);
    if (hit) return wb_data;
    if (ix == 0) return 32'h0;
    return m_rf[ix];
  endfunction

  task automatic tick(input string tag);
    logic [31:0] a, b;
    logic h1, h2;
    a = rd_op(rs1_id, h1);
    b = rd_op(rs2_id, h2);
    if (!reset_n) begin
      {e_a, e_b, e_r1, e_r2, e_v, e_h1, e_h2} = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      if (flush) begin
        {e_a, e_b, e_r1, e_r2, e_v, e_h1, e_h2} = '0;
      end else if (!stall) begin
        e_a = a; e_b = b;
        e_r1 = rs1_id; e_r2 = rs2_id;
        e_v = valid_id; e_h1 = h1; e_h2 = h2;
      end
      if (we_wb && rd_wb != 0) m_rf[rd_wb] = wb_data;
    end
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    reset_n = 0; rs1_id = 0; rs2_id = 0; valid_id = 0;
    rd_wb = 5'd3; we_wb = 1; wb_data = 32'hAAAA5555;
    stall = 0; flush = 0;
    #1;
    tick("rst0");
    tick("rst1");
    chk("rst.busA", busA_ex, 32'h0);
    chk("rst.vld", 32'(valid_ex), 32'h0);

    reset_n = 1; we_wb = 0; rs1_id = 3; valid_id = 1;
    tick("rel");
    chk("rel.busA", busA_ex, 32'h0);
    chk("rel.vld", 32'(valid_ex), 32'h1);

    we_wb = 1; rd_wb = 5; wb_data = 32'hDEADBEEF;
    tick("wr5");
    we_wb = 0; rs1_id = 5; rs2_id = 5;
    tick("rd5");
    chk("rd5.busA", busA_ex, 32'hDEADBEEF);
    chk("rd5.busB", busB_ex, 32'hDEADBEEF);
    chk("rd5.byp1", 32'(byp1_ex), 32'h0);

    we_wb = 1; rd_wb = 7; wb_data = 32'h11111111;
    tick("wr7");
    wb_data = 32'h12345678; rs1_id = 7; rs2_id = 9;
    tick("byp7");
    chk("byp7.busA", busA_ex, 32'h12345678);
    chk("byp7.byp1", 32'(byp1_ex), 32'h1);
    chk("byp7.byp2", 32'(byp2_ex), 32'h0);
    we_wb = 0;
    tick("rd7");
    chk("rd7.busA", busA_ex, 32'h12345678);
    chk("rd7.byp1", 32'(byp1_ex), 32'h0);

    we_wb = 1; rd_wb = 0; wb_data = 32'hFFFFFFFF; rs1_id = 0;
    tick("r0w");
    chk("r0w.busA", busA_ex, 32'h0);
    chk("r0w.byp1", 32'(byp1_ex), 32'h0);
    we_wb = 0;
    tick("r0r");
    chk("r0r.busA", busA_ex, 32'h0);

    rs1_id = 5;
    tick("cap5");
    stall = 1; we_wb = 1; rd_wb = 5; wb_data = 32'h0BADF00D;
    tick("stl0");
    we_wb = 0;
    tick("stl1");
    tick("stl2");
    chk("stl.busA", busA_ex, 32'hDEADBEEF);
    stall = 0;
    tick("stlr");
    chk("stlr.busA", busA_ex, 32'h0BADF00D);
    stall = 1; flush = 1;
    tick("sf");
    chk("sf.vld", 32'(valid_ex), 32'h0);
    chk("sf.busA", busA_ex, 32'h0);

    stall = 0; flush = 0; valid_id = 1;
    we_wb = 1; rd_wb = 4; wb_data = 32'h00000055;
    tick("wr4");
    reset_n = 0; stall = 1; wb_data = 32'h00000099;
    tick("mrst");
    chk("mrst.vld", 32'(valid_ex), 32'h0);
    chk("mrst.busA", busA_ex, 32'h0);
    reset_n = 1; stall = 0; we_wb = 0; rs1_id = 4;
    tick("rd4");
    chk("rd4.busA", busA_ex, 32'h0);

    for (int n = 0; n < 400; n++) begin
      reset_n  = ($urandom_range(0, 49) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      valid_id = $urandom_range(0, 1) == 1;
      we_wb    = $urandom_range(0, 1) == 1;
      rd_wb    = 5'($urandom_range(0, 7));
      rs1_id   = 5'($urandom_range(0, 1) == 1 ?
                    $urandom_range(0, 7) : $urandom_range(0, 31));
      rs2_id   = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
